// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, state encoding and word-index slice for the data-memory arbiter
package mem_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  // Byte address bits that select one of the 256 memory words.
  localparam int IDX_HI = 9;
  localparam int IDX_LO = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - two-input round-robin selector, favours the master that was not served last
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic sel
);
  assign sel = (req0 && req1) ? ~last : req1;
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-master arbiter with lock and burst limit for the data memory
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [8:0] MAX_B = MAX_BURST[8:0];

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic       g0, g1, beat0, beat1, err0, err1, good0, good1, pick;
  logic       own_req, own_lock, other_req;
  logic [8:0] cnt_inc;
  logic [7:0] cnt_sat;

  rr_pick u_rr_pick (
    .req0 (m0_req),
    .req1 (m1_req),
    .last (last_q),
    .sel  (pick)
  );

  assign g0    = (state_q == G0);
  assign g1    = (state_q == G1);
  assign beat0 = g0 && m0_req;
  assign beat1 = g1 && m1_req;
  assign err0  = beat0 && (m0_addr[1:0] != 2'b00);
  assign err1  = beat1 && (m1_addr[1:0] != 2'b00);
  assign good0 = beat0 && !err0;
  assign good1 = beat1 && !err1;

  assign own_req   = g0 ? m0_req  : m1_req;
  assign own_lock  = g0 ? m0_lock : m1_lock;
  assign other_req = g0 ? m1_req  : m0_req;
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  assign cnt_sat   = (cnt_q == 8'hFF) ? 8'hFF : cnt_inc[7:0];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (beat0) begin
      last_d = 1'b0;
    end else if (beat1) begin
      last_d = 1'b1;
    end
    case (state_q)
      G0, G1: begin
        // Lock lets the holder ignore the burst limit entirely.
        if (own_req && (own_lock || !other_req || (cnt_inc < MAX_B))) begin
          cnt_d = cnt_sat;
        end else if (other_req) begin
          state_d = g0 ? G1 : G0;
          cnt_d   = 8'd0;
        end else if (own_req) begin
          cnt_d = cnt_sat;
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        cnt_d = 8'd0;
        if (m0_req || m1_req) begin
          state_d = pick ? G1 : G0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  assign mem_addr  = g0 ? m0_addr  : (g1 ? m1_addr  : '0);
  assign mem_wdata = g0 ? m0_wdata : (g1 ? m1_wdata : '0);
  assign mem_write = (good0 && m0_we) || (good1 && m1_we);
  assign mem_read  = (good0 && !m0_we) || (good1 && !m1_we);

  assign m0_ack   = beat0;
  assign m1_ack   = beat1;
  assign m0_err   = err0;
  assign m1_err   = err1;
  assign m0_rdata = (good0 && !m0_we) ? mem_rdata : '0;
  assign m1_rdata = (good1 && !m1_we) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a scoreboard of expected beats
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clock, rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [15:0] m0_addr, m1_addr, mem_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err, mem_write, mem_read;

  logic [31:0] tmem [256];

  typedef struct {
    logic        m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter #(.MAX_BURST(8)) dut (
    .clock(clock), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rdata = tmem[mem_addr[IDX_HI:IDX_LO]];
  always @(posedge clock) if (mem_write) tmem[mem_addr[IDX_HI:IDX_LO]] <= mem_wdata;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sb.delete();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  task automatic finish_idle();
    clear_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    m0_req = 1; m1_req = 1; m0_addr = 16'h0044; m1_addr = 16'h0048;
    @(negedge clock);
    tests_run++;
    if ({m0_ack, m1_ack, m0_err, m1_err, mem_write, mem_read} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000000", {m0_ack, m1_ack, m0_err, m1_err, mem_write, mem_read});
    end
    tests_run++;
    if (mem_addr !== 16'h0 || mem_wdata !== 32'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    do_reset();
  endtask

  task automatic test_m0_read();
    exp_t e;
    do_reset();
    tmem[2] = 32'hDEADBEEF;
    m0_req = 1; m0_we = 0; m0_addr = 16'h0008;
    sb.push_back('{m: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    @(negedge clock);
    tests_run++;
    if (m0_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_cycle0_ack: got %b want 0", m0_ack);
    end
    next_cycle();
    @(negedge clock);
    tests_run++;
    if (m0_ack !== 1'b1 || mem_read !== 1'b1 || sb.size() == 0) begin
      tests_failed++;
      $display("FAIL read_cycle1: ack %b mem_read %b want 1 1", m0_ack, mem_read);
    end else begin
      e = sb.pop_front();
      if (m0_rdata !== e.rdata || m0_err !== e.err) begin
        tests_failed++;
        $display("FAIL read_data: got %h err %b want %h err %b", m0_rdata, m0_err, e.rdata, e.err);
      end
    end
    finish_idle();
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    tmem[0] = 32'h1000_0000;
    tmem[1] = 32'h2000_0001;
    m0_req = 1; m0_addr = 16'h0000;
    m1_req = 1; m1_addr = 16'h0004;
    for (int i = 0; i < 32; i++) begin
      if (((i / 8) % 2) == 0) sb.push_back('{m: 1'b0, rdata: 32'h1000_0000, err: 1'b0});
      else                    sb.push_back('{m: 1'b1, rdata: 32'h2000_0001, err: 1'b0});
    end
    @(negedge clock);
    tests_run++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_first_cycle: acks %b%b want 00", m0_ack, m1_ack);
    end
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      @(negedge clock);
      tests_run++;
      if ((m0_ack ^ m1_ack) !== 1'b1 || sb.size() == 0) begin
        tests_failed++;
        $display("FAIL rr_beat_%0d: acks %b%b want exactly one", i, m0_ack, m1_ack);
      end else begin
        e = sb.pop_front();
        if (m1_ack !== e.m || (e.m ? m1_rdata : m0_rdata) !== e.rdata) begin
          tests_failed++;
          $display("FAIL rr_beat_%0d: master %b want %b data %h want %h", i, m1_ack, e.m,
                   e.m ? m1_rdata : m0_rdata, e.rdata);
        end
      end
    end
    finish_idle();
  endtask

  task automatic test_lock();
    exp_t e;
    int bad;
    do_reset();
    tmem[4] = 32'h0;
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 16'h0010; m1_wdata = 32'h12345678;
    next_cycle();
    m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
    sb.push_back('{m: 1'b0, rdata: 32'h12345678, err: 1'b0});
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || mem_write !== 1'b1) bad++;
      next_cycle();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL lock_hold: %0d cycles lost grant want 0", bad);
    end
    m1_lock = 0;
    @(negedge clock);
    tests_run++;
    if (m1_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_release_beat: m1_ack %b want 1", m1_ack);
    end
    next_cycle();
    m1_req = 0; m1_we = 0;
    @(negedge clock);
    tests_run++;
    if (m0_ack !== 1'b1 || sb.size() == 0) begin
      tests_failed++;
      $display("FAIL lock_switch: m0_ack %b want 1", m0_ack);
    end else begin
      e = sb.pop_front();
      if (m0_rdata !== e.rdata) begin
        tests_failed++;
        $display("FAIL lock_readback: got %h want %h", m0_rdata, e.rdata);
      end
    end
    finish_idle();
  endtask

  task automatic test_misaligned();
    exp_t e;
    do_reset();
    tmem[1] = 32'hA5A5A5A5;
    m0_req = 1; m0_we = 1; m0_addr = 16'h0006; m0_wdata = 32'hFFFFFFFF;
    sb.push_back('{m: 1'b0, rdata: 32'h0, err: 1'b1});
    sb.push_back('{m: 1'b0, rdata: 32'hA5A5A5A5, err: 1'b0});
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests_run++;
      if (m0_ack !== 1'b1 || sb.size() == 0) begin
        tests_failed++;
        $display("FAIL misaligned_ack_%0d: got %b want 1", i, m0_ack);
      end else begin
        e = sb.pop_front();
        if (m0_err !== e.err || m0_rdata !== e.rdata || (e.err && mem_write !== 1'b0)) begin
          tests_failed++;
          $display("FAIL misaligned_beat_%0d: err %b data %h wr %b want err %b data %h",
                   i, m0_err, m0_rdata, mem_write, e.err, e.rdata);
        end
      end
      next_cycle();
      m0_we = 0; m0_addr = 16'h0004;
    end
    finish_idle();
  endtask

  task automatic test_single_burst();
    int missing;
    do_reset();
    tmem[8] = 32'h0000_5A5A;
    m0_req = 1; m0_addr = 16'h0020;
    next_cycle();
    missing = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (m0_ack !== 1'b1 || m0_rdata !== 32'h0000_5A5A) missing++;
      next_cycle();
    end
    tests_run++;
    if (missing != 0) begin
      tests_failed++;
      $display("FAIL burst_300: %0d beats missing want 0", missing);
    end
    m0_req = 0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    tests_run++;
    if (mem_addr !== 16'h0 || {m0_ack, m1_ack, mem_read, mem_write} !== 4'b0) begin
      tests_failed++;
      $display("FAIL burst_idle: addr %h ctrl %b want 0000 0", mem_addr, {m0_ack, m1_ack, mem_read, mem_write});
    end
    finish_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    tmem[12] = 32'hCAFE0000;
    m1_req = 1; m1_we = 1; m1_addr = 16'h0030; m1_wdata = 32'h0BADF00D;
    next_cycle();
    #2;
    tests_run++;
    if (mem_write !== 1'b1 || m1_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_pre: wr %b ack %b want 1 1", mem_write, m1_ack);
    end
    rst = 1;
    #1;
    tests_run++;
    if ({mem_write, mem_read, m1_ack, m0_ack} !== 4'b0 || mem_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL midreset_async: ctrl %b addr %h want 0000 0", {mem_write, mem_read, m1_ack, m0_ack}, mem_addr);
    end
    next_cycle();
    tests_run++;
    if (tmem[12] !== 32'hCAFE0000) begin
      tests_failed++;
      $display("FAIL midreset_nocommit: word %h want cafe0000", tmem[12]);
    end
    m1_we = 0; m0_req = 1; m0_addr = 16'h0000;
    rst = 0;
    next_cycle();
    @(negedge clock);
    tests_run++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_first_grant: acks m0 %b m1 %b want 1 0", m0_ack, m1_ack);
    end
    finish_idle();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_m0_read();
    test_round_robin();
    test_lock();
    test_misaligned();
    test_single_burst();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
